// File: rtl/mips_pkg.sv
// Shared MIPS pipeline types: register index/word widths and the writeback
// control bundle bit positions used by the EX/MEM and MEM/WB registers.
package mips_pkg;

  localparam int REG_IDX_W = 5;
  localparam int DATA_W    = 32;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0]    word_t;

  localparam reg_idx_t REG_ZERO = 5'd0;

  localparam int WB_REGWRITE = 0;
  localparam int WB_MEMTOREG = 1;
  localparam int WB_CTL_W    = 2;

endpackage

// File: rtl/regfile_2r1w.sv
// Architectural register file: one write port, two combinational read ports
// with same-cycle write-to-read bypass. Index 0 reads as zero.
module regfile_2r1w
  import mips_pkg::*;
#(
  parameter int NREGS = 32,
  parameter int DW    = 32,
  parameter int NRP   = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      we,
  input  reg_idx_t                  waddr,
  input  logic [DW-1:0]             wdata,
  input  logic [NRP-1:0][REG_IDX_W-1:0] raddr,
  output logic [NRP-1:0][DW-1:0]    rdata
);

  logic [NREGS-1:0][DW-1:0] regs;
  logic                     byp_en;

  // Entry 0 is cleared by reset and never written, so it stays zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      regs <= '0;
    else if (we && waddr != REG_ZERO)
      regs[waddr] <= wdata;
  end

  // A write presented during reset is discarded, so it must not bypass either.
  assign byp_en = we && !rst && (waddr != REG_ZERO);

  genvar p;
  for (p = 0; p < NRP; p++) begin : g_rd
    always_comb begin
      rdata[p] = regs[raddr[p]];
      if (raddr[p] == REG_ZERO)
        rdata[p] = '0;
      else if (byp_en && raddr[p] == waddr)
        rdata[p] = wdata;
    end
  end

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage: selects load/ALU result, commits it to the register file
// and counts retired writebacks.
module wb_regfile
  import mips_pkg::*;
#(
  parameter int NREGS = 32,
  parameter int DW    = 32,
  parameter int CW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          RegWrite,
  input  logic          MemToReg,
  input  logic [DW-1:0] readData,
  input  logic [DW-1:0] AluResult,
  input  reg_idx_t      rdORrt,
  input  reg_idx_t      rs_addr,
  input  reg_idx_t      rt_addr,
  output logic [DW-1:0] rs_data,
  output logic [DW-1:0] rt_data,
  output logic [DW-1:0] wb_data,
  output logic          wb_valid,
  output logic [CW-1:0] retire_cnt
);

  logic [WB_CTL_W-1:0]  wb_ctl;
  logic [1:0][DW-1:0]   rd_pair;

  assign wb_ctl[WB_REGWRITE] = RegWrite;
  assign wb_ctl[WB_MEMTOREG] = MemToReg;

  assign wb_data  = wb_ctl[WB_MEMTOREG] ? readData : AluResult;
  assign wb_valid = wb_ctl[WB_REGWRITE] && (rdORrt != REG_ZERO);

  regfile_2r1w #(
    .NREGS (NREGS),
    .DW    (DW),
    .NRP   (2)
  ) u_rf (
    .clk   (clk),
    .rst   (rst),
    .we    (wb_valid),
    .waddr (rdORrt),
    .wdata (wb_data),
    .raddr ({rt_addr, rs_addr}),
    .rdata (rd_pair)
  );

  assign rs_data = rd_pair[0];
  assign rt_data = rd_pair[1];

  // Free-running modulo counter of committed writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      retire_cnt <= '0;
    else if (wb_valid)
      retire_cnt <= retire_cnt + 1'b1;
  end

endmodule
